// File: rtl/delay_tap_trainer.sv
// delay_tap_trainer: sweeps delay taps 0..31 and centres DEL in the passing data window.
// Define DELAY_TRAIN_WIDEST_EN to sweep all taps and centre on the widest window instead of the first.
module delay_tap_trainer #(
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CNT    = 16
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       START,
  input  logic       SAMPLE,
  input  logic       EXPECT,
  output logic [4:0] DEL,
  output logic       BUSY,
  output logic       DONE,
  output logic       FAIL,
  output logic [4:0] LEFT_EDGE,
  output logic [4:0] RIGHT_EDGE
);
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_EVAL, S_CENTER, S_DONE, S_FAIL} state_t;
  state_t state, state_n;
  logic [7:0] cnt;
  logic mism, win_open, best_valid, pass, last, close_win, take, stop, settle_end, sample_end;
  logic [4:0] cur_left, cur_right, best_left, best_right, cl, cr;

  assign BUSY = !(state == S_IDLE || state == S_DONE || state == S_FAIL);
  assign DONE = state == S_DONE;
  assign FAIL = state == S_FAIL;

  // DEL doubles as the current tap while sweeping; cl/cr describe the window as it stands after this tap
  always_comb begin
    settle_end = cnt == 8'(SETTLE_CYCLES - 1);
    sample_end = cnt == 8'(SAMPLE_CNT - 1);
    pass = !mism;
    last = DEL == 5'd31;
    close_win = (win_open && !pass) || (pass && last);
    cl = win_open ? cur_left : DEL;
    cr = pass ? DEL : cur_right;
`ifdef DELAY_TRAIN_WIDEST_EN
    take = close_win && (!best_valid || (cr - cl) > (best_right - best_left));
    stop = last;
`else
    take = close_win;
    stop = last || close_win;
`endif
    state_n = state;
    case (state)
      S_IDLE, S_DONE, S_FAIL: state_n = START ? S_SETTLE : state;
      S_SETTLE: state_n = settle_end ? S_SAMPLE : S_SETTLE;
      S_SAMPLE: state_n = sample_end ? S_EVAL : S_SAMPLE;
      S_EVAL:   state_n = stop ? S_CENTER : S_SETTLE;
      S_CENTER: state_n = best_valid ? S_DONE : S_FAIL;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) state <= S_IDLE;
    else state <= state_n;

  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      cnt        <= '0;
      DEL        <= '0;
      mism       <= 1'b0;
      win_open   <= 1'b0;
      best_valid <= 1'b0;
      cur_left   <= '0;
      cur_right  <= '0;
      best_left  <= '0;
      best_right <= '0;
      LEFT_EDGE  <= '0;
      RIGHT_EDGE <= '0;
    end else begin
      cnt <= ((state == S_SETTLE && !settle_end) || (state == S_SAMPLE && !sample_end)) ? cnt + 8'd1 : 8'd0;
      case (state)
        S_IDLE, S_DONE, S_FAIL:
          if (START) begin
            DEL        <= '0;
            mism       <= 1'b0;
            win_open   <= 1'b0;
            best_valid <= 1'b0;
            LEFT_EDGE  <= '0;
            RIGHT_EDGE <= '0;
          end
        S_SAMPLE: mism <= mism || (SAMPLE != EXPECT);
        S_EVAL: begin
          win_open <= pass;
          mism     <= 1'b0;
          if (pass) begin
            cur_left  <= cl;
            cur_right <= DEL;
          end
          if (take) begin
            best_valid <= 1'b1;
            best_left  <= cl;
            best_right <= cr;
          end
          if (!stop) DEL <= DEL + 5'd1;
        end
        S_CENTER: begin
          DEL        <= best_valid ? 5'(({1'b0, best_left} + {1'b0, best_right}) >> 1) : 5'd0;
          LEFT_EDGE  <= best_valid ? best_left : 5'd0;
          RIGHT_EDGE <= best_valid ? best_right : 5'd0;
        end
        default: ;
      endcase
    end
endmodule
